// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_if
//  Description : Byte-stream input and instruction-memory write bundle for
//                imem_loader. The slave modport is the loader's view; the
//                master modport is the view of whatever feeds bytes in and
//                watches the write/status outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface imem_loader_if #(
    parameter int I_ADDR_W = 12,
    parameter int INST_W   = 16
);

    // Byte stream from the host link
    logic [7:0]          rx_data;
    logic                rx_valid;
    logic                rx_ready;

    // Instruction memory write port
    logic                imem_we;
    logic [I_ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0]   imem_wdata;

    // CPU control and load status
    logic                cpu_hold;
    logic                load_done;
    logic                load_error;

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata,
        output cpu_hold,
        output load_done,
        output load_error
    );

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata,
        input  cpu_hold,
        input  load_done,
        input  load_error
    );

endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Receives a framed byte stream (SYNC, LEN_LO, LEN_HI,
//                little-endian instruction payload, 8-bit additive checksum)
//                and writes each assembled instruction into instruction
//                memory while holding the CPU in reset. The CPU is released
//                only once a frame has been fully received with a matching
//                checksum.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int          I_ADDR_W       = 12,
    parameter int          INST_W         = 16,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 100000
) (
    input  wire           clk,
    input  wire           reset,
    imem_loader_if.slave  bus
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int INST_W_BYTES = (INST_W + 7) / 8;
    localparam int c_BCNT_W     = (INST_W_BYTES > 1) ? $clog2(INST_W_BYTES) : 1;
    localparam int c_IDLE_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_ASM_W      = INST_W_BYTES * 8;

    localparam logic [c_BCNT_W-1:0] c_LAST_BYTE    = c_BCNT_W'(INST_W_BYTES - 1);
    localparam logic [c_BCNT_W-1:0] c_BCNT_ONE     = c_BCNT_W'(1);
    localparam logic [c_IDLE_W-1:0] c_TIMEOUT_LAST = c_IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_ONE     = c_IDLE_W'(1);
    localparam logic [I_ADDR_W-1:0] c_ADDR_ONE     = I_ADDR_W'(1);
    // Largest legal LEN is the full memory depth
    localparam logic [32:0]         c_MAX_LEN      = 33'd1 << I_ADDR_W;

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LEN_LO   = 3'd1,
        S_LEN_HI   = 3'd2,
        S_PAYLOAD  = 3'd3,
        S_CHECKSUM = 3'd4,
        S_DONE     = 3'd5,
        S_ERROR    = 3'd6
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t              r_state;
    logic [7:0]          r_len_lo;
    logic [I_ADDR_W-1:0] r_last_idx;   // LEN-1: index of the final instruction
    logic [I_ADDR_W-1:0] r_addr;       // address counter, also drives imem_addr
    logic [c_BCNT_W-1:0] r_byte_cnt;   // byte position within current instruction
    logic [c_ASM_W-1:0]  r_asm;        // partially assembled instruction
    logic [7:0]          r_sum;        // running payload checksum
    logic [c_IDLE_W-1:0] r_idle_cnt;   // cycles since the last accepted in-frame byte
    logic                r_imem_we;
    logic [INST_W-1:0]   r_imem_wdata;
    logic                r_cpu_hold;
    logic                r_load_done;
    logic                r_load_error;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic                w_rx_ready;
    logic                w_accept;
    logic                w_is_sync;
    logic                w_in_frame;
    logic [15:0]         w_len;
    logic                w_len_bad;
    logic [c_ASM_W-1:0]  w_asm_next;

    // The single write cycle is the only time a byte cannot be taken, so the
    // address counter and byte counter never see a payload byte and a write
    // completion in the same cycle.
    assign w_rx_ready = ~reset & ~r_imem_we;
    assign w_accept   = bus.rx_valid & w_rx_ready;
    assign w_is_sync  = (bus.rx_data == SYNC_BYTE);
    assign w_in_frame = (r_state == S_LEN_LO)  || (r_state == S_LEN_HI) ||
                        (r_state == S_PAYLOAD) || (r_state == S_CHECKSUM);
    assign w_len      = {bus.rx_data, r_len_lo};
    assign w_len_bad  = (w_len == 16'd0) || (33'(w_len) > c_MAX_LEN);

    // Drop the incoming byte into its little-endian slot of the instruction
    always_comb begin
        w_asm_next = r_asm;
        w_asm_next[int'(r_byte_cnt) * 8 +: 8] = bus.rx_data;
    end

    // Frame-parsing FSM with registered write strobe and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_len_lo     <= '0;
            r_last_idx   <= '0;
            r_addr       <= '0;
            r_byte_cnt   <= '0;
            r_asm        <= '0;
            r_sum        <= '0;
            r_idle_cnt   <= '0;
            r_imem_we    <= 1'b0;
            r_imem_wdata <= '0;
            r_cpu_hold   <= 1'b1;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
        end else begin
            r_imem_we <= 1'b0;

            case (r_state)
                // Outside a frame only a sync byte matters; it restarts all
                // per-frame bookkeeping and re-asserts the CPU hold.
                S_IDLE, S_DONE, S_ERROR: begin
                    r_idle_cnt <= '0;
                    if (w_accept && w_is_sync) begin
                        r_state      <= S_LEN_LO;
                        r_load_done  <= 1'b0;
                        r_load_error <= 1'b0;
                        r_cpu_hold   <= 1'b1;
                        r_addr       <= '0;
                        r_byte_cnt   <= '0;
                        r_sum        <= '0;
                    end
                end

                S_LEN_LO: begin
                    if (w_accept) begin
                        r_len_lo <= bus.rx_data;
                        r_state  <= S_LEN_HI;
                    end
                end

                // Reject empty frames and frames larger than the memory
                // before any write is issued.
                S_LEN_HI: begin
                    if (w_accept) begin
                        if (w_len_bad) begin
                            r_state      <= S_ERROR;
                            r_load_error <= 1'b1;
                        end else begin
                            r_last_idx <= I_ADDR_W'(w_len - 16'd1);
                            r_state    <= S_PAYLOAD;
                        end
                    end
                end

                // The cycle after a write advances the address; after the
                // last instruction the next byte is the checksum.
                S_PAYLOAD: begin
                    if (r_imem_we) begin
                        r_addr <= r_addr + c_ADDR_ONE;
                        if (r_addr == r_last_idx) begin
                            r_state <= S_CHECKSUM;
                        end
                    end else if (w_accept) begin
                        r_sum <= r_sum + bus.rx_data;
                        r_asm <= w_asm_next;
                        if (r_byte_cnt == c_LAST_BYTE) begin
                            r_byte_cnt   <= '0;
                            r_imem_we    <= 1'b1;
                            r_imem_wdata <= w_asm_next[INST_W-1:0];
                        end else begin
                            r_byte_cnt <= r_byte_cnt + c_BCNT_ONE;
                        end
                    end
                end

                S_CHECKSUM: begin
                    if (w_accept) begin
                        if (bus.rx_data == r_sum) begin
                            r_state     <= S_DONE;
                            r_load_done <= 1'b1;
                            r_cpu_hold  <= 1'b0;
                        end else begin
                            r_state      <= S_ERROR;
                            r_load_error <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state      <= S_ERROR;
                    r_load_error <= 1'b1;
                end
            endcase

            // Inter-byte watchdog: a stalled link inside a frame aborts it.
            // Writes already made are left in place.
            if (w_in_frame) begin
                if (w_accept) begin
                    r_idle_cnt <= '0;
                end else if (r_idle_cnt == c_TIMEOUT_LAST) begin
                    r_idle_cnt   <= '0;
                    r_state      <= S_ERROR;
                    r_load_error <= 1'b1;
                    r_load_done  <= 1'b0;
                    r_cpu_hold   <= 1'b1;
                end else begin
                    r_idle_cnt <= r_idle_cnt + c_IDLE_ONE;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.rx_ready   = w_rx_ready;
    assign bus.imem_we    = r_imem_we;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_imem_wdata;
    assign bus.cpu_hold   = r_cpu_hold;
    assign bus.load_done  = r_load_done;
    assign bus.load_error = r_load_error;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Self-checking bench for imem_loader. A frame-level reference
//                model predicts the memory writes and final status of every
//                frame; a separate monitor pops the expected writes as the DUT
//                strobes imem_we.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int         AW   = 4;       // small memory so LEN limits are reachable
    localparam int         IW   = 16;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam int         TO   = 40;

    localparam int ST_PEND = 0;
    localparam int ST_DONE = 1;
    localparam int ST_ERR  = 2;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [IW-1:0] data;
    } wr_t;

    logic clk;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    wr_t  exp_q[$];
    wr_t  mon_e;

    imem_loader_if #(.I_ADDR_W(AW), .INST_W(IW)) bus ();

    imem_loader #(
        .I_ADDR_W       (AW),
        .INST_W         (IW),
        .SYNC_BYTE      (SYNC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Frame-level reference: decode the byte list by the frame rules, queue
    // every complete instruction write and return the resulting status.
    function automatic int model_frame(input logic [7:0] fr[$]);
        int         len;
        logic [7:0] sum;
        if (fr.size() < 3) return ST_PEND;
        len = int'({fr[2], fr[1]});
        if (len == 0 || len > (1 << AW)) return ST_ERR;
        for (int i = 0; i < len; i++) begin
            if (fr.size() < 5 + 2 * i) return ST_PEND;
            exp_q.push_back('{addr: AW'(i), data: {fr[4 + 2 * i], fr[3 + 2 * i]}});
        end
        if (fr.size() < 4 + 2 * len) return ST_PEND;
        sum = 8'h00;
        for (int j = 3; j < 3 + 2 * len; j++) sum = sum + fr[j];
        return (fr[3 + 2 * len] == sum) ? ST_DONE : ST_ERR;
    endfunction

    // Present one byte and hold it until the DUT takes it; returns at the
    // falling edge after the accepting rising edge.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int guard;
        if (gaps) begin
            bus.rx_valid = 1'b0;
            bus.rx_data  = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        guard = 0;
        while (bus.rx_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) begin
            n_tests++;
            n_fail++;
            $display("FAIL rx_ready_timeout: got rx_ready=%b, expected 1", bus.rx_ready);
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic check_status(input int st);
        check("load_done",  {31'd0, bus.load_done},  {31'd0, st == ST_DONE});
        check("load_error", {31'd0, bus.load_error}, {31'd0, st == ST_ERR});
        check("cpu_hold",   {31'd0, bus.cpu_hold},   {31'd0, st != ST_DONE});
    endtask

    task automatic run_frame(input logic [7:0] fr[$], input bit gaps);
        int st;
        st = model_frame(fr);
        foreach (fr[i]) send_byte(fr[i], gaps);
        check_status(st);
        repeat (2) @(negedge clk);
        check("writes_drained", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_we",    {31'd0, bus.imem_we},      32'd0);
        check("rst_addr",  32'(bus.imem_addr),        32'd0);
        check("rst_wdata", 32'(bus.imem_wdata),       32'd0);
        check("rst_hold",  {31'd0, bus.cpu_hold},     32'd1);
        check("rst_done",  {31'd0, bus.load_done},    32'd0);
        check("rst_err",   {31'd0, bus.load_error},   32'd0);
        check("rst_ready", {31'd0, bus.rx_ready},     32'd0);
    endtask

    // Scoreboard monitor: every write strobe must match the head of the
    // expected queue, and the loader must not be accepting bytes meanwhile.
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got addr=%0h data=%0h, expected no write",
                         bus.imem_addr, bus.imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr",  32'(bus.imem_addr),  32'(mon_e.addr));
                check("write_data",  32'(bus.imem_wdata), 32'(mon_e.data));
            end
            check("ready_low_during_we", {31'd0, bus.rx_ready}, 32'd0);
        end
    end

    // Global watchdog so the bench always terminates
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] fr[$];
        logic [7:0] sum;
        logic [7:0] g;
        int         len;
        int         st;

        reset        = 1'b1;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {31'd0, bus.rx_ready}, 32'd1);
        check_status(ST_PEND);

        // Two-instruction frame with correct payload checksum (0x14)
        fr = '{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h14};
        run_frame(fr, 1'b0);

        // Same frame with wrong checksums: writes still land, frame fails
        fr = '{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'hC6};
        run_frame(fr, 1'b0);
        fr = '{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'hC7};
        run_frame(fr, 1'b0);

        // Zero length, then a one-instruction frame recovering from ERROR
        fr = '{8'hA5, 8'h00, 8'h00};
        run_frame(fr, 1'b0);
        fr = '{8'hA5, 8'h01, 8'h00, 8'hFF, 8'hFF, 8'hFE};
        run_frame(fr, 1'b0);

        // One past the memory depth is rejected
        fr = '{8'hA5, 8'h11, 8'h00};
        run_frame(fr, 1'b0);

        // Exactly the memory depth is accepted
        fr = '{8'hA5, 8'h10, 8'h00};
        sum = 8'h00;
        for (int i = 0; i < 32; i++) begin
            g = 8'($urandom);
            fr.push_back(g);
            sum = sum + g;
        end
        fr.push_back(sum);
        run_frame(fr, 1'b0);

        // Sync value inside the payload is plain data
        fr = '{8'hA5, 8'h01, 8'h00, 8'hA5, 8'hA5, 8'h4A};
        run_frame(fr, 1'b0);

        // Stalled link mid-frame: error exactly TO idle cycles after last byte
        fr = '{8'hA5, 8'h01, 8'h00, 8'h11};
        st = model_frame(fr);
        foreach (fr[i]) send_byte(fr[i], 1'b0);
        repeat (TO - 1) @(negedge clk);
        check_status(st);
        @(negedge clk);
        check_status(ST_ERR);
        check("timeout_no_write", exp_q.size(), 0);

        // Reset after three payload bytes: one write, then a clean restart
        fr = '{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78};
        st = model_frame(fr);
        foreach (fr[i]) send_byte(fr[i], 1'b0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        check("reset_one_write", exp_q.size(), 0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_midreset", {31'd0, bus.rx_ready}, 32'd1);
        fr = '{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h14};
        run_frame(fr, 1'b0);

        // Randomized frames with garbage prefix and random valid gaps
        for (int n = 0; n < 12; n++) begin
            repeat ($urandom_range(0, 3)) begin
                g = 8'($urandom);
                if (g == SYNC) g = 8'h5A;
                send_byte(g, 1'b1);
            end
            len = (n == 0) ? 2 : $urandom_range(1, 1 << AW);
            fr = '{SYNC, 8'(len), 8'(len >> 8)};
            sum = 8'h00;
            for (int i = 0; i < 2 * len; i++) begin
                g = (n == 0) ? ((i == 0) ? 8'h34 : (i == 1) ? 8'h12 : (i == 2) ? 8'h78 : 8'h56)
                             : 8'($urandom);
                fr.push_back(g);
                sum = sum + g;
            end
            if ($urandom_range(0, 3) == 0 && n != 0) sum = sum + 8'd1;
            fr.push_back(sum);
            run_frame(fr, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
